md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit for the E stage of the pipelined MIPS core. It accepts the 4-bit `md_sel` operation produced by the decode controller, runs mult/multu/div/divu with configurable latency, and holds the HI/LO registers. It raises a stall request toward D while busy, and supports a synchronous `cancel` that aborts an in-flight operation without touching HI/LO. Relative to the fixed-width, fixed-timing MDU, width and per-operation latency are parameters.

## Interface
- `W`, 32: operand, HI and LO width.
- `MULT_CYC`, 5: busy cycles for mult/multu, ≥1.
- `DIV_CYC`, 10: busy cycles for div/divu, ≥1.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `md_sel` in 4: E-stage operation, using the shared encodings `md_none/mult/multu/div/divu/mfhi/mflo/mthi/mtlo`.
- `valid` in 1: E-stage instruction is real, not a bubble.
- `a` in W: forwarded rs value.
- `b` in W: forwarded rt value.
- `cancel` in 1: abort the current operation, sampled at the clock edge.
- `d_md` in 1: the D-stage instruction is any md/mf/mt op.
- `start` out 1: combinational. A mult/div is being accepted this cycle.
- `busy` out 1: registered. An operation is in flight.
- `stall_req` out 1: combinational. Equals `d_md & (start | busy)`.
- `hi`, `lo` out W: committed HI and LO.
- `rdata` out W: combinational. Equals `hi` for mfhi, `lo` for mflo, 0 otherwise.

## Operation
- FSM has two states, IDLE and BUSY. A down-counter `cnt` is sized to `$clog2(max(MULT_CYC,DIV_CYC)+1)`.
- `start = valid & ~busy & ~cancel & (md_sel ∈ {mult, multu, div, divu})`.
- On `start`:
  - Latch the result into shadow registers `p_hi`/`p_lo`.
  - Load `cnt` with the op's CYC value.
  - Go to BUSY.
- In BUSY, `cnt` decrements each cycle. When `cnt==1` at an edge, copy `p_hi`/`p_lo` into `hi`/`lo` and go to IDLE.
- Result of mult/multu: the 2W product, upper half to `p_hi`, lower half to `p_lo`. Signed or unsigned per op.
- Result of div: quotient to `p_lo`, remainder to `p_hi`. The quotient truncates toward zero, and the remainder takes the sign of the dividend. divu is unsigned.
- Divide by zero (div and divu): `p_lo = {W{1'b1}}`, `p_hi = a`.
- Signed overflow (−2^(W−1) / −1): `p_lo = −2^(W−1)`, `p_hi = 0`.
- mthi/mtlo:
  - When `valid & ~busy & ~cancel`, write `a` to HI or LO at the edge.
  - While busy they are ignored. This is a protocol violation, and the bench asserts on it.
- A mult/div arriving while busy is ignored. This is also a protocol violation.
- `cancel`:
  - In BUSY: go to IDLE and clear `cnt`. HI and LO keep their pre-operation values.
  - In IDLE: it suppresses `start` and mt in the same cycle.
- Reset state: `hi = lo = p_hi = p_lo = 0`, `cnt = 0`, IDLE, `busy = 0`.
- Reset mid-operation returns to the reset state immediately, and the pending result is discarded.

## Timing
- Start at edge *t*: `busy` is high for edges *t*+1 through *t*+CYC. The new `hi`/`lo` are visible after edge *t*+CYC, and `busy` falls at the same edge.
- A back-to-back md op in D is stalled by `stall_req` from the start cycle through the last busy cycle. It issues to E on the cycle `busy` is low.
- mt takes effect at the next edge. An mf in the following cycle reads the new value.
- `rdata` has zero latency and always reflects committed `hi`/`lo`.

## Structure
- Shared constants file: the `md_sel` encodings (`md_none` … `md_mtlo`), shared with the decode controller.
- One combinational sub-module, `md_arith`: takes `a`, `b` and the op and returns the 2W `{hi,lo}` result, including the divide-by-zero and overflow rules.
- `md_unit` holds the FSM, the counter, the shadow registers and HI/LO.

## Test plan
- W=32, MULT_CYC=5: mult a=−3, b=5. Expect `busy` high for 5 cycles, then `hi=0xFFFFFFFF`, `lo=0xFFFFFFF1`. During the operation, `d_md=1` gives `stall_req=1` every cycle.
- div a=−7, b=2 gives `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`. divu a=7, b=2 gives `lo=3`, `hi=1`. Both take DIV_CYC=10 cycles.
- divu a=0x1234, b=0 gives `lo=0xFFFFFFFF`, `hi=0x1234`. div 0x80000000 / 0xFFFFFFFF gives `lo=0x80000000`, `hi=0`.
- mthi a=0xDEAD, then mfhi on the next cycle: `rdata=0xDEAD`. mtlo issued together with `cancel=1` leaves `lo` unchanged.
- mult with preloaded `hi=lo=0x11`, `cancel` asserted on busy cycle 3. Expect `busy=0` next cycle and `hi=lo=0x11`. A new mult accepted right after completes normally.
- `reset` pulled low mid-div between edges: outputs go to 0 and `busy` to 0 without waiting for a clock edge. After release the unit is in IDLE.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared md_sel encodings and FSM state type for the multiply/divide unit
package md_unit_pkg;
    typedef enum logic [3:0] {
        md_none  = 4'd0,
        md_mult  = 4'd1,
        md_multu = 4'd2,
        md_div   = 4'd3,
        md_divu  = 4'd4,
        md_mfhi  = 4'd5,
        md_mflo  = 4'd6,
        md_mthi  = 4'd7,
        md_mtlo  = 4'd8
    } md_op_e;

    typedef enum logic {
        st_idle = 1'b0,
        st_busy = 1'b1
    } md_state_e;

    function automatic logic is_mul(input logic [3:0] op);
        return op == md_mult || op == md_multu;
    endfunction

    function automatic logic is_md(input logic [3:0] op);
        return op == md_mult || op == md_multu || op == md_div || op == md_divu;
    endfunction
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational mult/multu/div/divu datapath returning {hi,lo}
//   a, b : operands (rs, rt)
//   op   : md_sel encoding
//   res  : {hi, lo}; product for mult, {remainder, quotient} for div
module md_arith
    import md_unit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [3:0]     op,
    output logic [2*W-1:0] res
);
    logic [2*W-1:0] prod_s, prod_u;
    logic signed [W-1:0] sq, sr;
    logic [W-1:0] uq, ur;
    logic b_zero, s_ovf;

    // Explicit extension to 2W keeps the product width independent of context rules
    assign prod_s = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    assign prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};

    // SV signed / and % already truncate toward zero with remainder following the dividend
    assign sq = $signed(a) / $signed(b);
    assign sr = $signed(a) % $signed(b);
    assign uq = a / b;
    assign ur = a % b;

    assign b_zero = b == '0;
    assign s_ovf  = a == {1'b1, {(W-1){1'b0}}} && b == '1;

    always_comb begin
        res = '0;
        case (op)
            md_mult:  res = prod_s;
            md_multu: res = prod_u;
            md_div:   res = b_zero ? {a, {W{1'b1}}} :
                            s_ovf  ? {{W{1'b0}}, a} :
                                     {sr, sq};
            md_divu:  res = b_zero ? {a, {W{1'b1}}} : {ur, uq};
            default:  res = '0;
        endcase
    end
endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with HI/LO, configurable latency, stall and cancel
//   clk, reset     : clock, async active-low reset
//   md_sel, valid  : E-stage operation and its validity
//   a, b           : forwarded rs / rt
//   cancel         : abort in-flight op, suppress start/mt in idle
//   d_md           : D-stage instruction is an md/mf/mt op
//   start          : mult/div accepted this cycle
//   busy           : operation in flight
//   stall_req      : hold D while an md op is pending
//   hi, lo, rdata  : committed HI/LO and mf read data
module md_unit
    import md_unit_pkg::*;
#(
    parameter int W        = 32,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   md_sel,
    input  logic         valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cancel,
    input  logic         d_md,
    output logic         start,
    output logic         busy,
    output logic         stall_req,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic [W-1:0] rdata
);
    localparam int MAXC = MULT_CYC > DIV_CYC ? MULT_CYC : DIV_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e     state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  p_hi, p_lo;
    logic [2*W-1:0] res;
    logic          mt_ok;

    md_arith #(.W(W)) u_arith (
        .a   (a),
        .b   (b),
        .op  (md_sel),
        .res (res)
    );

    assign busy      = state == st_busy;
    assign mt_ok     = valid & ~busy & ~cancel;
    assign start     = mt_ok & is_md(md_sel);
    assign stall_req = d_md & (start | busy);
    assign rdata     = md_sel == md_mfhi ? hi : md_sel == md_mflo ? lo : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= st_idle;
            cnt   <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == st_idle) begin
            if (start) begin
                {p_hi, p_lo} <= res;
                cnt          <= is_mul(md_sel) ? CW'(MULT_CYC) : CW'(DIV_CYC);
                state        <= st_busy;
            end else if (mt_ok && md_sel == md_mthi) begin
                hi <= a;
            end else if (mt_ok && md_sel == md_mtlo) begin
                lo <= a;
            end
        end else if (cancel) begin
            state <= st_idle;
            cnt   <= '0;
        end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                hi    <= p_hi;
                lo    <= p_lo;
                state <= st_idle;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int W = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   md_sel;
    logic         valid;
    logic [W-1:0] a, b;
    logic         cancel;
    logic         d_md;
    logic         start, busy, stall_req;
    logic [W-1:0] hi, lo, rdata;

    int tests = 0;
    int fails = 0;

    md_unit #(.W(W), .MULT_CYC(MC), .DIV_CYC(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_sel    (md_sel),
        .valid     (valid),
        .a         (a),
        .b         (b),
        .cancel    (cancel),
        .d_md      (d_md),
        .start     (start),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        valid  = 1'b0;
        md_sel = md_none;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
    endtask

    // Issue one mult/div, check busy/stall every busy cycle, then check committed result
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] xa,
                         input logic [W-1:0] xb, input int cyc,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo);
        logic [W-1:0] old_hi;
        old_hi = hi;
        md_sel = op; valid = 1'b1; a = xa; b = xb; d_md = 1'b1;
        #1;
        chk({tag, "_start"}, 64'(start), 64'd1);
        chk({tag, "_stall0"}, 64'(stall_req), 64'd1);
        step();
        idle_in();
        for (int i = 0; i < cyc; i++) begin
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            chk({tag, "_stall"}, 64'(stall_req), 64'd1);
            chk({tag, "_hi_held"}, 64'(hi), 64'(old_hi));
            step();
        end
        chk({tag, "_done"}, 64'(busy), 64'd0);
        chk({tag, "_stall_off"}, 64'(stall_req), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(lo), 64'(elo));
        d_md = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        d_md  = 1'b0;
        idle_in();
        step();
        step();
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        do_op("mult", md_mult, -32'sd3, 32'd5, MC, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_op("multu", md_multu, 32'hFFFF_FFFF, 32'd2, MC, 32'h0000_0001, 32'hFFFF_FFFE);
        do_op("div", md_div, -32'sd7, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu", md_divu, 32'd7, 32'd2, DC, 32'd1, 32'd3);
        do_op("divu0", md_divu, 32'h1234, 32'd0, DC, 32'h1234, 32'hFFFF_FFFF);
        do_op("divovf", md_div, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000);

        md_sel = md_mthi; valid = 1'b1; a = 32'hDEAD;
        step();
        md_sel = md_mfhi; a = '0;
        #1;
        chk("mfhi_rdata", 64'(rdata), 64'hDEAD);
        md_sel = md_mflo;
        #1;
        chk("mflo_rdata", 64'(rdata), 64'h8000_0000);
        md_sel = md_none;
        #1;
        chk("none_rdata", 64'(rdata), 64'd0);

        md_sel = md_mtlo; a = 32'h5555; cancel = 1'b1;
        step();
        chk("mtlo_cancel", 64'(lo), 64'h8000_0000);
        md_sel = md_mult;
        #1;
        chk("start_cancel", 64'(start), 64'd0);
        step();
        chk("busy_cancel", 64'(busy), 64'd0);
        idle_in();

        valid = 1'b1; md_sel = md_mthi; a = 32'h11;
        step();
        md_sel = md_mtlo;
        step();
        md_sel = md_mult; a = 32'd2; b = 32'd3;
        step();
        idle_in();
        step();
        step();
        chk("cbusy3", 64'(busy), 64'd1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        chk("cancel_hi", 64'(hi), 64'h11);
        chk("cancel_lo", 64'(lo), 64'h11);
        do_op("after_cancel", md_mult, 32'd2, 32'd3, MC, 32'd0, 32'd6);

        md_sel = md_div; valid = 1'b1; a = 32'd100; b = 32'd7;
        step();
        idle_in();
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_rst_idle", 64'(busy), 64'd0);
        do_op("divu_post", md_divu, 32'd100, 32'd7, DC, 32'd2, 32'd14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
